// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the PLL reset / tick controller.
// The FSM encoding and default timing constants also feed the host register
// map, so keep the encoding stable when extending it.
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } ctrl_state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_LOCK_STABLE = 1024;
    localparam int DEF_RELEASE_DLY = 16;
    localparam int DEF_TICK_DIV    = 7000;
    localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk     destination clock
//   rst     asynchronous active-high reset, clears the whole chain
//   sig     asynchronous input level
//   synced  sig after STAGES flops in the clk domain
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic synced
);

    logic [STAGES-1:0] chain;

    // Shift the raw level through the chain; only the last flop is used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], sig};
        end
    end

    assign synced = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_tick_ctrl.sv
// Lock-qualified reset generator and sim-core tick controller.
// Runs in the PLL output clock domain. Holds the sim core in reset until the
// PLL has been locked for LOCK_STABLE cycles plus RELEASE_DLY extra cycles,
// then produces tick strobes either free-running (run_en=1, one every
// TICK_DIV cycles) or on host request (run_en=0, one per step_req).
// Ports:
//   clk            PLL output clock
//   rst            asynchronous active-high reset
//   locked         PLL lock flag, asynchronous to clk
//   run_en         1 = free-run ticks, 0 = step mode
//   step_req       single-cycle request for one tick while paused
//   sys_rst        synchronous active-high reset to the sim core
//   ready          high only while running
//   tick_en        single-cycle tick strobe
//   tick_count     ticks since the last sys_rst release (wrapping)
//   lock_loss_cnt  lock drops seen while running (saturating)
module pll_reset_tick_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LOCK_STABLE = DEF_LOCK_STABLE,
    parameter int RELEASE_DLY = DEF_RELEASE_DLY,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             locked,
    input  logic             run_en,
    input  logic             step_req,
    output logic             sys_rst,
    output logic             ready,
    output logic             tick_en,
    output logic [CNT_W-1:0] tick_count,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    localparam int STAB_W = $clog2(LOCK_STABLE + 1);
    localparam int REL_W  = $clog2(RELEASE_DLY + 1);
    localparam int DIV_W  = $clog2(TICK_DIV);

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);
    localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(RELEASE_DLY - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);

    ctrl_state_t       state;
    logic              locked_s;
    logic [STAB_W-1:0] stab_cnt;
    logic [REL_W-1:0]  rel_cnt;
    logic [DIV_W-1:0]  div_cnt;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk    (clk),
        .rst    (rst),
        .sig    (locked),
        .synced (locked_s)
    );

    // Single FSM process: lock qualification, reset release, tick generation
    // and statistics. Every output is a flop so the sim core sees glitch-free
    // sys_rst and tick_en. Losing lock in RUN wins over any tick that would
    // have fired on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= WAIT_LOCK;
            stab_cnt      <= '0;
            rel_cnt       <= '0;
            div_cnt       <= '0;
            sys_rst       <= 1'b1;
            ready         <= 1'b0;
            tick_en       <= 1'b0;
            tick_count    <= '0;
            lock_loss_cnt <= '0;
        end else begin
            tick_en <= 1'b0;
            case (state)
                WAIT_LOCK: begin
                    sys_rst    <= 1'b1;
                    ready      <= 1'b0;
                    tick_count <= '0;
                    div_cnt    <= '0;
                    if (locked_s) begin
                        state    <= STABILIZE;
                        stab_cnt <= '0;
                    end
                end
                STABILIZE: begin
                    sys_rst    <= 1'b1;
                    ready      <= 1'b0;
                    tick_count <= '0;
                    div_cnt    <= '0;
                    if (!locked_s) begin
                        state <= WAIT_LOCK;
                    end else if (stab_cnt == STAB_LAST) begin
                        state   <= RELEASE;
                        rel_cnt <= '0;
                    end else begin
                        stab_cnt <= stab_cnt + STAB_W'(1);
                    end
                end
                RELEASE: begin
                    ready      <= 1'b0;
                    tick_count <= '0;
                    div_cnt    <= '0;
                    if (!locked_s) begin
                        state   <= WAIT_LOCK;
                        sys_rst <= 1'b1;
                    end else if (rel_cnt == REL_LAST) begin
                        // Release and ready change on the same edge as entering RUN.
                        state   <= RUN;
                        sys_rst <= 1'b0;
                        ready   <= 1'b1;
                    end else begin
                        sys_rst <= 1'b1;
                        rel_cnt <= rel_cnt + REL_W'(1);
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state      <= WAIT_LOCK;
                        sys_rst    <= 1'b1;
                        ready      <= 1'b0;
                        tick_count <= '0;
                        div_cnt    <= '0;
                        if (lock_loss_cnt != '1) begin
                            lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
                        end
                    end else if (run_en) begin
                        // Free-run: a step request here is simply ignored.
                        sys_rst <= 1'b0;
                        ready   <= 1'b1;
                        if (div_cnt == DIV_LAST) begin
                            div_cnt    <= '0;
                            tick_en    <= 1'b1;
                            tick_count <= tick_count + CNT_W'(1);
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end else begin
                        // Paused: divider restarts from zero when run_en returns.
                        sys_rst <= 1'b0;
                        ready   <= 1'b1;
                        div_cnt <= '0;
                        if (step_req) begin
                            tick_en    <= 1'b1;
                            tick_count <= tick_count + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state   <= WAIT_LOCK;
                    sys_rst <= 1'b1;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_tick_ctrl.sv
// Bench for pll_reset_tick_ctrl with small timing parameters.
// A reference model tracks how many consecutive clock edges the synchronized
// lock flag has been high; the controller is running once that streak covers
// the one WAIT_LOCK edge plus LOCK_STABLE plus RELEASE_DLY edges.
module tb_pll_reset_tick_ctrl;

    localparam int SYNC_STAGES = 2;
    localparam int LOCK_STABLE = 8;
    localparam int RELEASE_DLY = 4;
    localparam int TICK_DIV    = 5;
    localparam int CNT_W       = 16;
    localparam int RUN_AFTER   = 1 + LOCK_STABLE + RELEASE_DLY;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             locked = 1'b0;
    logic             run_en = 1'b0;
    logic             step_req = 1'b0;
    logic             sys_rst;
    logic             ready;
    logic             tick_en;
    logic [CNT_W-1:0] tick_count;
    logic [CNT_W-1:0] lock_loss_cnt;

    int checks_total  = 0;
    int checks_passed = 0;

    pll_reset_tick_ctrl #(
        .SYNC_STAGES (SYNC_STAGES),
        .LOCK_STABLE (LOCK_STABLE),
        .RELEASE_DLY (RELEASE_DLY),
        .TICK_DIV    (TICK_DIV),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .locked        (locked),
        .run_en        (run_en),
        .step_req      (step_req),
        .sys_rst       (sys_rst),
        .ready         (ready),
        .tick_en       (tick_en),
        .tick_count    (tick_count),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    typedef struct {
        logic [SYNC_STAGES-1:0] sync;
        int                     streak;
        int                     run_cycles;
        logic                   tick;
        logic [CNT_W-1:0]       count;
        logic [CNT_W-1:0]       loss;
    } model_t;

    model_t m;

    function automatic model_t model_next(input model_t cur, input logic lk,
                                          input logic re, input logic sr);
        model_t nxt;
        logic   ls;
        bit     in_run;
        nxt    = cur;
        ls     = cur.sync[SYNC_STAGES-1];
        in_run = (cur.streak >= RUN_AFTER);
        nxt.tick = 1'b0;
        nxt.sync = {cur.sync[SYNC_STAGES-2:0], lk};
        if (!ls) begin
            nxt.streak     = 0;
            nxt.run_cycles = 0;
            if (in_run && cur.loss != {CNT_W{1'b1}}) nxt.loss = cur.loss + 1'b1;
        end else begin
            nxt.streak = (cur.streak < RUN_AFTER) ? cur.streak + 1 : RUN_AFTER;
            if (in_run && re) begin
                nxt.run_cycles = cur.run_cycles + 1;
                nxt.tick = ((nxt.run_cycles % TICK_DIV) == 0);
            end else begin
                nxt.run_cycles = 0;
                nxt.tick = in_run && sr;
            end
        end
        if (nxt.streak < RUN_AFTER) nxt.count = '0;
        else if (nxt.tick) nxt.count = cur.count + 1'b1;
        return nxt;
    endfunction

    // Model advances on the same edges as the DUT, inputs being stable then.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m <= '{sync: '0, streak: 0, run_cycles: 0, tick: 1'b0, count: '0, loss: '0};
        end else begin
            m <= model_next(m, locked, run_en, step_req);
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks_total++;
        if (actual == expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check_output("model_ready", int'(ready), int'(m.streak >= RUN_AFTER));
            check_output("model_sys_rst", int'(sys_rst), int'(m.streak < RUN_AFTER));
            check_output("model_tick_en", int'(tick_en), int'(m.tick));
            check_output("model_tick_count", int'(tick_count), int'(m.count));
            check_output("model_lock_loss", int'(lock_loss_cnt), int'(m.loss));
        end
    end

    typedef struct {
        logic lk;
        logic re;
        logic sr;
        int   cycles;
        logic exp_ready;
        logic exp_sys_rst;
        int   exp_tc;
        int   exp_loss;
    } vec_t;

    vec_t vecs[17];

    // Called at a negedge: drive inputs, let n edges pass, land on a negedge.
    task automatic apply_stimulus(input logic lk, input logic re, input logic sr, input int n);
        locked   = lk;
        run_en   = re;
        step_req = sr;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        locked = 1'b0;
        run_en = 1'b0;
        step_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Hand-derived expectations with the bench parameters
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 50, 1'b0, 1'b1, 0, 0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0,  8, 1'b0, 1'b1, 0, 0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0,  6, 1'b0, 1'b1, 0, 0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 14, 1'b0, 1'b1, 0, 0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b0, 0, 0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 24, 1'b1, 1'b0, 4, 0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0,  1, 1'b1, 1'b0, 5, 0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0,  4, 1'b1, 1'b0, 5, 0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b0, 5, 0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0,  5, 1'b1, 1'b0, 5, 0};
        vecs[10] = '{1'b1, 1'b0, 1'b1,  3, 1'b1, 1'b0, 8, 0};
        vecs[11] = '{1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b0, 8, 0};
        vecs[12] = '{1'b1, 1'b1, 1'b0,  5, 1'b1, 1'b0, 9, 0};
        vecs[13] = '{1'b0, 1'b1, 1'b0,  2, 1'b1, 1'b0, 9, 0};
        vecs[14] = '{1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b1, 0, 1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b1, 0, 1};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 15, 1'b1, 1'b0, 0, 1};

        repeat (2) @(negedge clk);
        check_output("reset_sys_rst", int'(sys_rst), 1);
        check_output("reset_ready", int'(ready), 0);
        check_output("reset_tick_en", int'(tick_en), 0);
        check_output("reset_tick_count", int'(tick_count), 0);
        check_output("reset_lock_loss", int'(lock_loss_cnt), 0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            apply_stimulus(vecs[i].lk, vecs[i].re, vecs[i].sr, vecs[i].cycles);
            check_output($sformatf("vec%0d_ready", i), int'(ready), int'(vecs[i].exp_ready));
            check_output($sformatf("vec%0d_sys_rst", i), int'(sys_rst), int'(vecs[i].exp_sys_rst));
            check_output($sformatf("vec%0d_tick_count", i), int'(tick_count), vecs[i].exp_tc);
            check_output($sformatf("vec%0d_lock_loss", i), int'(lock_loss_cnt), vecs[i].exp_loss);
        end

        // Lock loss seen on the very edge the divider would wrap: no tick.
        pulse_reset();
        apply_stimulus(1'b1, 1'b1, 1'b0, 27);
        check_output("collide_pre_tick_count", int'(tick_count), 2);
        apply_stimulus(1'b0, 1'b1, 1'b0, 2);
        check_output("collide_still_ready", int'(ready), 1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1);
        check_output("collide_tick_en", int'(tick_en), 0);
        check_output("collide_ready", int'(ready), 0);
        check_output("collide_lock_loss", int'(lock_loss_cnt), 1);
        check_output("collide_tick_count", int'(tick_count), 0);

        // Randomized run against the model
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(79) == 0) locked = ~locked;
            if ($urandom_range(24) == 0) run_en = ~run_en;
            step_req = ($urandom_range(2) == 0);
            @(negedge clk);
        end

        // Async reset in the middle of RUN, checked before the next edge
        apply_stimulus(1'b1, 1'b1, 1'b0, 40);
        check_output("async_pre_ready", int'(ready), 1);
        #2;
        rst = 1'b1;
        #1;
        check_output("async_sys_rst", int'(sys_rst), 1);
        check_output("async_ready", int'(ready), 0);
        check_output("async_tick_en", int'(tick_en), 0);
        check_output("async_tick_count", int'(tick_count), 0);
        check_output("async_lock_loss", int'(lock_loss_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0, 3);
        check_output("async_after_ready", int'(ready), 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
